// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain driver: register map, sequencer
// states and the fixed power-up register programme.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam logic [3:0] INIT_LAST_WORD = 4'd4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_PREP,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } state_e;

  // {addr, data} for word idx of the power-up programme.
  function automatic logic [15:0] init_word(input logic [3:0] idx,
                                            input logic [7:0] scan_limit,
                                            input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {REG_TEST, 8'h00};
      4'd1:    w = {REG_SCANLIMIT, scan_limit};
      4'd2:    w = {REG_DECODE, 8'h00};
      4'd3:    w = {REG_INTENSITY, 4'h0, intensity};
      4'd4:    w = {REG_SHUTDOWN, 8'h01};
      default: w = {REG_NOOP, 8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/max7219_serializer.sv
// MSB-first shift register with serial-clock divider. One bit takes
// 2*CLK_DIV cycles: sclk low for CLK_DIV, then high for CLK_DIV. dout only
// moves on the edge that starts a bit (sclk low).
module max7219_serializer #(
  parameter int unsigned W       = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_word,
  output logic         o_sclk,
  output logic         o_dout,
  output logic         o_word_done
);

  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [W-1:0]  sr_q, sr_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          dout_q, dout_d;
  logic          active_q, active_d;

  logic div_wrap;
  logic last_bit;

  assign div_wrap    = (div_q == DW'(CLK_DIV - 1));
  assign last_bit    = (cnt_q == BW'(1));
  assign o_word_done = active_q & sclk_q & div_wrap & last_bit;
  assign o_sclk      = sclk_q;
  assign o_dout      = dout_q;

  // Next-state: load a word, then step the divider and emit bits.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sclk_d   = sclk_q;
    dout_d   = dout_q;
    active_d = active_q;
    if (i_load) begin
      // The MSB goes straight to dout; sr_q keeps the bits still to send.
      sr_d     = {i_word[W-2:0], 1'b0};
      dout_d   = i_word[W-1];
      cnt_d    = BW'(W);
      div_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (div_wrap) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (last_bit) begin
            active_d = 1'b0;
          end else begin
            dout_d = sr_q[W-1];
            sr_d   = {sr_q[W-2:0], 1'b0};
            cnt_d  = cnt_q - BW'(1);
          end
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // Serializer registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      dout_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      dout_q   <= dout_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/max7219_chain_driver.sv
// Sequencer for a chain of MAX7219 devices: power-up register programme,
// then on request a frame of intensity, shutdown and digit registers.
module max7219_chain_driver
  import max7219_pkg::*;
#(
  parameter int unsigned N_DEVICES = 1,
  parameter int unsigned N_DIGITS  = 8,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic                            i_start,
  input  logic [N_DEVICES*N_DIGITS*8-1:0] i_digits,
  input  logic [3:0]                      i_intensity,
  input  logic                            i_blank,
  output logic                            o_busy,
  output logic                            o_done_stb,
  output logic                            o_serial_load,
  output logic                            o_serial_dout,
  output logic                            o_serial_clk
);

  localparam int unsigned W     = 16 * N_DEVICES;
  localparam int unsigned DIG_W = N_DEVICES * N_DIGITS * 8;
  localparam int unsigned LW    = $clog2(2 * CLK_DIV);

  localparam logic [7:0] SCAN_LIMIT      = 8'(N_DIGITS - 1);
  localparam logic [3:0] FRAME_LAST_WORD = 4'(N_DIGITS + 1);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             mode_init_q, mode_init_d;
  logic [3:0]       word_q, word_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [3:0]       int_q, int_d;
  logic             blank_q, blank_d;
  logic [DIG_W-1:0] digits_q, digits_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]   w_addr;
  logic [7:0]   w_data;
  logic [W-1:0] ser_word;
  logic         ser_load;
  logic         ser_done;
  logic         last_word;
  logic         frame_go;

  assign last_word = mode_init_q ? (word_q == INIT_LAST_WORD)
                                 : (word_q == FRAME_LAST_WORD);

  // Word mux: common address, per-device data; device N_DEVICES-1 in the MSBs.
  always_comb begin
    w_addr = REG_NOOP;
    w_data = '0;
    if (mode_init_q) begin
      {w_addr, w_data} = init_word(word_q, SCAN_LIMIT, int_q);
    end else if (word_q == 4'd0) begin
      w_addr = REG_INTENSITY;
      w_data = {4'h0, int_q};
    end else if (word_q == 4'd1) begin
      w_addr = REG_SHUTDOWN;
      w_data = {7'b0, ~blank_q};
    end else begin
      w_addr = REG_DIGIT0 + {4'h0, word_q} - 8'd2;
    end
    ser_word = '0;
    for (int unsigned k = 0; k < N_DEVICES; k++) begin
      ser_word[k*16 +: 16] = {w_addr, w_data};
      if (!mode_init_q) begin
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
          if (word_q == 4'(d + 2)) begin
            ser_word[k*16 +: 8] = digits_q[(k*N_DIGITS + d)*8 +: 8];
          end
        end
      end
    end
  end

  // Sequencer next-state and output decisions.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | (i_start & (state_q != ST_IDLE));
    mode_init_d = mode_init_q;
    word_d      = word_q;
    lat_d       = lat_q;
    int_d       = int_q;
    blank_d     = blank_q;
    digits_d    = digits_q;
    load_d      = load_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ser_load    = 1'b0;
    frame_go    = 1'b0;
    case (state_q)
      // INIT also acts as the PREP of the first init word, so the
      // programme starts shifting on the first cycle out of reset.
      ST_INIT: begin
        int_d       = i_intensity;
        mode_init_d = 1'b1;
        word_d      = '0;
        ser_load    = 1'b1;
        load_d      = 1'b0;
        busy_d      = 1'b1;
        state_d     = ST_SHIFT;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_start || pending_q) begin
          frame_go  = 1'b1;
          pending_d = 1'b0;
        end
      end
      ST_PREP: begin
        ser_load = 1'b1;
        load_d   = 1'b0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        lat_d = '0;
        if (ser_done) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LW'(CLK_DIV - 1)) load_d = 1'b1;
        if (lat_q == LW'(2 * CLK_DIV - 1)) begin
          lat_d = '0;
          if (last_word) begin
            state_d = ST_DONE;
          end else begin
            word_d  = word_q + 4'd1;
            state_d = ST_PREP;
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (pending_q) begin
          frame_go  = 1'b1;
          pending_d = i_start;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_go) begin
      digits_d    = i_digits;
      int_d       = i_intensity;
      blank_d     = i_blank;
      mode_init_d = 1'b0;
      word_d      = '0;
      busy_d      = 1'b1;
      state_d     = ST_PREP;
    end
  end

  // Sequencer registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ST_INIT;
      pending_q   <= 1'b0;
      mode_init_q <= 1'b1;
      word_q      <= '0;
      lat_q       <= '0;
      int_q       <= '0;
      blank_q     <= 1'b0;
      digits_q    <= '0;
      load_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mode_init_q <= mode_init_d;
      word_q      <= word_d;
      lat_q       <= lat_d;
      int_q       <= int_d;
      blank_q     <= blank_d;
      digits_q    <= digits_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  max7219_serializer #(
    .W       (W),
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_load      (ser_load),
    .i_word      (ser_word),
    .o_sclk      (o_serial_clk),
    .o_dout      (o_serial_dout),
    .o_word_done (ser_done)
  );

  assign o_busy        = busy_q;
  assign o_done_stb    = done_q;
  assign o_serial_load = load_q;

endmodule
